bcd_adder: RTL and testbench
============================

// Module: bcd_adder
// PURPOSE
//   Registered BCD adder: adds two packed-BCD operands A and B (DIGITS decimal
//   digits each) and presents the BCD sum plus decimal carry-out one clock later.
//   Arithmetic building block for the fixed-point/decimal datapath. DIGITS=1
//   gives the single-digit adder (0..9 + 0..9 -> 0..18).
// PARAMETERS
//   DIGITS   1   number of BCD digits per operand (>=1); operand width W=4*DIGITS
// PORTS
//   clk       in   1   rising-edge clock; single clock domain
//   rst_n     in   1   asynchronous, active-low reset
//   A         in   W   addend 1, packed BCD, digit 0 in A[3:0]
//   B         in   W   addend 2, packed BCD, digit 0 in B[3:0]
//   Sum       out  W   registered BCD sum, digit 0 in Sum[3:0]
//   Cout      out  1   registered decimal carry out of the top digit
//   out_valid out  1   high once first post-reset result is registered
//   err       out  1   registered: some operand digit of the sampled A/B was >9
// BEHAVIOUR
//   - Reset (rst_n=0, async): Sum=0, Cout=0, out_valid=0, err=0 immediately.
//   - No handshake: A/B sampled every rising edge; outputs reflect operands of
//     previous edge (latency 1 cycle, throughput 1/cycle). Outputs stable between edges.
//   - out_valid goes 1 on first rising edge with rst_n=1, stays 1 until reset.
//   - Per digit i (ripple, c0=0): s = a_i + b_i + c_i (5-bit binary, max 31).
//     If s > 9: d_i = (s + 6) mod 16, c_{i+1} = 1; else d_i = s, c_{i+1} = 0.
//     Cout = c_DIGITS. Carry chain purely combinational within the cycle.
//   - Valid range: each digit 0..9. Examples: 9+9 -> Sum=8,Cout=1; 5+5 -> 0,1;
//     4+5 -> 9,0; 0+0 -> 0,0.
//   - Invalid digit (>9) in A or B: err=1 for that result; Sum/Cout still follow
//     the rule above unchanged (e.g. 12+3: s=15 -> Sum=5, Cout=1, err=1).
//     err is not sticky; clears on next valid operand pair.
//   - Reset asserted mid-stream: outputs clear at once; the first edge after
//     release registers the current A/B, no stale value appears.
//   - X/Z on A/B: no requirement beyond propagation; bench keeps inputs driven.
// STRUCTURE
//   - Package bcd_pkg: localparam BCD_MAX=4'd9, BCD_ADJ=4'd6, typedef bcd_digit_t
//     (logic [3:0]).
//   - Sub-module bcd_digit_add (combinational): inputs a,b[3:0], cin; outputs
//     d[3:0], cout, bad (a>9 | b>9). Instantiated DIGITS times via generate,
//     ripple-chained; err = OR of all bad.
//   - Top: generate chain + one output register stage (Sum, Cout, err, out_valid).
// TESTING (clk period 10 ns)
//   - Reset: hold rst_n=0, A=7,B=8 -> Sum=0,Cout=0,err=0,out_valid=0; release ->
//     next edge Sum=5,Cout=1,out_valid=1.
//   - Exhaustive DIGITS=1: A,B each 0..9 (100 pairs, new pair every 100 ns) ->
//     one cycle later Sum=(A+B)%10, Cout=(A+B>=10), err=0.
//   - Boundaries: 4+5 -> 9,0; 5+5 -> 0,1; 9+9 -> 8,1; 0+0 -> 0,0.
//   - Invalid: A=12,B=3 -> Sum=5,Cout=1,err=1; then A=1,B=1 -> Sum=2,Cout=0,err=0.
//   - Latency: change A/B every cycle -> each result appears exactly 1 edge later.
//   - DIGITS=2: A=0x99,B=0x01 -> Sum=0x00,Cout=1 (carry ripples across digits);
//     async reset asserted mid-cycle -> outputs 0 before next edge.

Source files
------------

// File: rtl/bcd_pkg.sv
// Shared BCD types and constants for the decimal datapath.
package bcd_pkg;

   localparam logic [3:0] BCD_MAX = 4'd9;
   localparam logic [3:0] BCD_ADJ = 4'd6;

   typedef logic [3:0] bcd_digit_t;

   function automatic logic bcd_invalid(input bcd_digit_t x);
      return x > BCD_MAX;
   endfunction

endpackage

// File: rtl/bcd_digit_add.sv
// Combinational single-digit BCD adder with carry in/out and invalid-digit flag.
module bcd_digit_add
   import bcd_pkg::*;
(
   input  bcd_digit_t a,
   input  bcd_digit_t b,
   input  logic       cin,
   output bcd_digit_t d,
   output logic       cout,
   output logic       bad
);

   logic [4:0] s;

   always_comb begin
      s = {1'b0, a} + {1'b0, b} + {4'b0000, cin};
      // 4-bit wrap of s[3:0] + 6 equals (s + 6) mod 16, also for out-of-range digits
      if (s > {1'b0, BCD_MAX}) begin
         d    = s[3:0] + BCD_ADJ;
         cout = 1'b1;
      end else begin
         d    = s[3:0];
         cout = 1'b0;
      end
      bad = bcd_invalid(a) | bcd_invalid(b);
   end

endmodule

// File: rtl/bcd_adder.sv
// Registered packed-BCD adder: ripple chain of digit adders, one output register stage.
module bcd_adder
   import bcd_pkg::*;
#(
   parameter int unsigned DIGITS = 1,
   localparam int unsigned W = 4 * DIGITS
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [W-1:0] A,
   input  logic [W-1:0] B,
   output logic [W-1:0] Sum,
   output logic         Cout,
   output logic         out_valid,
   output logic         err
);

   logic [DIGITS:0]   carry;
   logic [DIGITS-1:0] bad;
   logic [W-1:0]      sum_d, sum_q;
   logic              cout_d, cout_q;
   logic              err_d, err_q;
   logic              valid_q;

   assign carry[0] = 1'b0;

   for (genvar i = 0; i < DIGITS; i++) begin : g_digit
      bcd_digit_add u_digit (
         .a    (A[4*i +: 4]),
         .b    (B[4*i +: 4]),
         .cin  (carry[i]),
         .d    (sum_d[4*i +: 4]),
         .cout (carry[i+1]),
         .bad  (bad[i])
      );
   end

   always_comb begin
      cout_d = carry[DIGITS];
      err_d  = |bad;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sum_q   <= '0;
         cout_q  <= 1'b0;
         err_q   <= 1'b0;
         valid_q <= 1'b0;
      end else begin
         sum_q   <= sum_d;
         cout_q  <= cout_d;
         err_q   <= err_d;
         valid_q <= 1'b1;
      end
   end

   assign Sum       = sum_q;
   assign Cout      = cout_q;
   assign err       = err_q;
   assign out_valid = valid_q;

endmodule

// File: tb/tb_bcd_adder.sv
// Self-checking bench for bcd_adder: DIGITS=1 and DIGITS=2 instances, queue scoreboards.
module tb_bcd_adder;

   typedef struct {
      logic [7:0] sum;
      logic       cout;
      logic       err;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst_n = 1'b1;
   logic [3:0] a1 = 4'd0, b1 = 4'd0;
   logic [7:0] a2 = 8'h00, b2 = 8'h00;
   logic [3:0] sum1;
   logic [7:0] sum2;
   logic       cout1, valid1, err1;
   logic       cout2, valid2, err2;

   exp_t q1[$];
   exp_t q2[$];
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   bcd_adder #(.DIGITS(1)) dut1 (
      .clk       (clk),
      .rst_n     (rst_n),
      .A         (a1),
      .B         (b1),
      .Sum       (sum1),
      .Cout      (cout1),
      .out_valid (valid1),
      .err       (err1)
   );

   bcd_adder #(.DIGITS(2)) dut2 (
      .clk       (clk),
      .rst_n     (rst_n),
      .A         (a2),
      .B         (b2),
      .Sum       (sum2),
      .Cout      (cout2),
      .out_valid (valid2),
      .err       (err2)
   );

   // Decimal-value model for valid single-digit operands
   task automatic drive1(input int a, input int b);
      exp_t e;
      int   s;
      s      = a + b;
      e.sum  = 8'(s % 10);
      e.cout = (s >= 10);
      e.err  = 1'b0;
      a1     = 4'(a);
      b1     = 4'(b);
      q1.push_back(e);
   endtask

   task automatic drive1_const(input int a, input int b, input int s, input bit c, input bit er);
      exp_t e;
      e.sum  = 8'(s);
      e.cout = c;
      e.err  = er;
      a1     = 4'(a);
      b1     = 4'(b);
      q1.push_back(e);
   endtask

   task automatic drive2(input logic [7:0] a, input logic [7:0] b);
      exp_t e;
      int   s;
      s      = int'(a[7:4]) * 10 + int'(a[3:0]) + int'(b[7:4]) * 10 + int'(b[3:0]);
      e.sum  = {4'((s % 100) / 10), 4'(s % 10)};
      e.cout = (s >= 100);
      e.err  = 1'b0;
      a2     = a;
      b2     = b;
      q2.push_back(e);
   endtask

   task automatic test_reset();
      exp_t e;
      #1 rst_n = 1'b0;
      a1 = 4'd7;
      b1 = 4'd8;
      repeat (3) @(posedge clk);
      #3;
      checks++;
      if ({sum1, cout1, err1, valid1} !== 7'b0) begin
         errors++;
         $display("FAIL reset_hold1 got sum=%h cout=%b err=%b valid=%b want all 0",
                  sum1, cout1, err1, valid1);
      end
      checks++;
      if ({sum2, cout2, err2, valid2} !== 11'b0) begin
         errors++;
         $display("FAIL reset_hold2 got sum=%h cout=%b err=%b valid=%b want all 0",
                  sum2, cout2, err2, valid2);
      end
      @(posedge clk);
      #1;
      drive1_const(7, 8, 5, 1'b1, 1'b0);
      drive2(8'h00, 8'h00);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      e = q1.pop_front();
      checks++;
      if ({sum1, cout1, err1, valid1} !== {e.sum[3:0], e.cout, e.err, 1'b1}) begin
         errors++;
         $display("FAIL reset_release got sum=%h cout=%b err=%b valid=%b want sum=%h cout=%b err=%b valid=1",
                  sum1, cout1, err1, valid1, e.sum[3:0], e.cout, e.err);
      end
      void'(q2.pop_front());
   endtask

   task automatic test_exhaustive();
      exp_t e;
      for (int a = 0; a < 10; a++) begin
         for (int b = 0; b < 10; b++) begin
            drive1(a, b);
            @(posedge clk);
            #1;
            if (q1.size() == 0) begin
               errors++;
               $display("FAIL exh_queue empty at a=%0d b=%0d", a, b);
            end else begin
               e = q1.pop_front();
               checks++;
               if ({sum1, cout1, err1, valid1} !== {e.sum[3:0], e.cout, e.err, 1'b1}) begin
                  errors++;
                  $display("FAIL exh %0d+%0d got sum=%h cout=%b err=%b valid=%b want sum=%h cout=%b err=%b",
                           a, b, sum1, cout1, err1, valid1, e.sum[3:0], e.cout, e.err);
               end
               repeat (9) @(posedge clk);
               #1;
               checks++;
               if ({sum1, cout1, err1} !== {e.sum[3:0], e.cout, e.err}) begin
                  errors++;
                  $display("FAIL exh_hold %0d+%0d got sum=%h cout=%b want sum=%h cout=%b",
                           a, b, sum1, cout1, e.sum[3:0], e.cout);
               end
            end
         end
      end
   endtask

   task automatic test_boundaries();
      exp_t e;
      int   ta[4] = '{4, 5, 9, 0};
      int   tb[4] = '{5, 5, 9, 0};
      int   ts[4] = '{9, 0, 8, 0};
      bit   tc[4] = '{1'b0, 1'b1, 1'b1, 1'b0};
      for (int i = 0; i < 4; i++) begin
         drive1_const(ta[i], tb[i], ts[i], tc[i], 1'b0);
         @(posedge clk);
         #1;
         e = q1.pop_front();
         checks++;
         if ({sum1, cout1, err1, valid1} !== {e.sum[3:0], e.cout, e.err, 1'b1}) begin
            errors++;
            $display("FAIL boundary %0d+%0d got sum=%h cout=%b err=%b want sum=%h cout=%b err=0",
                     ta[i], tb[i], sum1, cout1, err1, e.sum[3:0], e.cout);
         end
      end
   endtask

   task automatic test_invalid();
      exp_t e;
      drive1_const(12, 3, 5, 1'b1, 1'b1);
      @(posedge clk);
      #1;
      drive1_const(1, 1, 2, 1'b0, 1'b0);
      e = q1.pop_front();
      checks++;
      if ({sum1, cout1, err1} !== {e.sum[3:0], e.cout, e.err}) begin
         errors++;
         $display("FAIL invalid_12_3 got sum=%h cout=%b err=%b want sum=5 cout=1 err=1",
                  sum1, cout1, err1);
      end
      @(posedge clk);
      #1;
      e = q1.pop_front();
      checks++;
      if ({sum1, cout1, err1} !== {e.sum[3:0], e.cout, e.err}) begin
         errors++;
         $display("FAIL invalid_clear got sum=%h cout=%b err=%b want sum=2 cout=0 err=0",
                  sum1, cout1, err1);
      end
   endtask

   task automatic test_latency();
      exp_t e;
      int   a, b;
      for (int i = 0; i < 40; i++) begin
         a = int'($urandom_range(0, 9));
         b = int'($urandom_range(0, 9));
         drive1(a, b);
         drive2({4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))},
                {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))});
         @(posedge clk);
         #1;
         e = q1.pop_front();
         checks++;
         if ({sum1, cout1, err1} !== {e.sum[3:0], e.cout, e.err}) begin
            errors++;
            $display("FAIL latency1 cyc=%0d got sum=%h cout=%b want sum=%h cout=%b",
                     i, sum1, cout1, e.sum[3:0], e.cout);
         end
         e = q2.pop_front();
         checks++;
         if ({sum2, cout2, err2, valid2} !== {e.sum, e.cout, e.err, 1'b1}) begin
            errors++;
            $display("FAIL latency2 cyc=%0d got sum=%h cout=%b err=%b want sum=%h cout=%b",
                     i, sum2, cout2, err2, e.sum, e.cout);
         end
      end
   endtask

   task automatic test_digits2();
      exp_t       e;
      logic [7:0] va[3] = '{8'h99, 8'h50, 8'h45};
      logic [7:0] vb[3] = '{8'h01, 8'h50, 8'h38};
      for (int i = 0; i < 3; i++) begin
         drive2(va[i], vb[i]);
         @(posedge clk);
         #1;
         e = q2.pop_front();
         checks++;
         if ({sum2, cout2, err2, valid2} !== {e.sum, e.cout, e.err, 1'b1}) begin
            errors++;
            $display("FAIL d2 %h+%h got sum=%h cout=%b err=%b want sum=%h cout=%b",
                     va[i], vb[i], sum2, cout2, err2, e.sum, e.cout);
         end
      end
      // 0x45+0x38 = 0x83 is now registered; reset mid-cycle must clear it before the next edge
      #3 rst_n = 1'b0;
      #1;
      checks++;
      if ({sum2, cout2, err2, valid2} !== 11'b0) begin
         errors++;
         $display("FAIL d2_async_reset got sum=%h cout=%b err=%b valid=%b want all 0",
                  sum2, cout2, err2, valid2);
      end
      q1.delete();
      drive2(8'h27, 8'h15);
      #1 rst_n = 1'b1;
      @(posedge clk);
      #1;
      e = q2.pop_front();
      checks++;
      if ({sum2, cout2, err2, valid2} !== {e.sum, e.cout, e.err, 1'b1}) begin
         errors++;
         $display("FAIL d2_after_reset got sum=%h cout=%b valid=%b want sum=%h cout=%b valid=1",
                  sum2, cout2, valid2, e.sum, e.cout);
      end
   endtask

   initial begin
      test_reset();
      test_exhaustive();
      test_boundaries();
      test_invalid();
      test_latency();
      test_digits2();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
